// File: rtl/operand_fetch_stage_pkg.sv
// Shared types for the operand fetch stage and its ALU neighbour.
// Widths, shift/ALU encodings, FSM states and the latched command.
package operand_fetch_stage_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int ADDR_W = $clog2(NREGS);

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    ADD  = 2'b00,
    SUB  = 2'b01,
    AND  = 2'b10,
    NOTB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LOAD_A  = 2'b01,
    LOAD_B  = 2'b10,
    PRESENT = 2'b11
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    shift_e            shift;
    logic              asel;
    logic              bsel;
    logic [DATA_W-1:0] imm;
    alu_op_e           op;
  } cmd_t;

endpackage

// File: rtl/operand_fetch_stage_b_shifter.sv
// B-path single-bit shifter, purely combinational.
// Shared later with the datapath.
module b_shifter
  import operand_fetch_stage_pkg::*;
(
  input  logic [DATA_W-1:0] b,
  input  shift_e            op,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = b;
    unique case (op)
      SH_NONE: y = b;
      SH_LSL:  y = {b[DATA_W-2:0], 1'b0};
      SH_LSR:  y = {1'b0, b[DATA_W-1:1]};
      SH_ASR:  y = {b[DATA_W-1], b[DATA_W-1:1]};
      default: y = b;
    endcase
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Register file plus two-cycle operand fetch into A/B snapshots,
// presented to the ALU under a valid/accept handshake.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] writenum,
  input  logic [DATA_W-1:0] data_in,
  input  logic              start,
  input  logic [ADDR_W-1:0] readnum_a,
  input  logic [ADDR_W-1:0] readnum_b,
  input  logic [1:0]        shift,
  input  logic              asel,
  input  logic              bsel,
  input  logic [DATA_W-1:0] imm,
  input  logic [1:0]        alu_op_in,
  input  logic              accept,
  output logic              busy,
  output logic              valid,
  output logic [DATA_W-1:0] ain,
  output logic [DATA_W-1:0] bin,
  output logic [1:0]        alu_op
);

  state_e            state;
  state_e            state_n;
  cmd_t              cmd;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] sh_b;
  logic              present;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (write) begin
      regs[writenum] <= data_in;
    end
  end

  // Same-edge writeback wins over the stale register value.
  assign rd_a = (write && writenum == cmd.ra)
              ? data_in : regs[cmd.ra];
  assign rd_b = (write && writenum == cmd.rb)
              ? data_in : regs[cmd.rb];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = LOAD_A;
      LOAD_A:  state_n = LOAD_B;
      LOAD_B:  state_n = PRESENT;
      PRESENT: if (accept) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cmd <= '{ra:    readnum_a,
                     rb:    readnum_b,
                     shift: shift_e'(shift),
                     asel:  asel,
                     bsel:  bsel,
                     imm:   imm,
                     op:    alu_op_e'(alu_op_in)};
          end
        end
        LOAD_A:  a_q <= rd_a;
        LOAD_B:  b_q <= rd_b;
        default: ;
      endcase
    end
  end

  b_shifter u_shift (
    .b  (b_q),
    .op (cmd.shift),
    .y  (sh_b)
  );

  assign present = (state == PRESENT);
  assign busy    = (state != IDLE);
  assign valid   = present;
  assign alu_op  = cmd.op;

  always_comb begin
    ain = '0;
    bin = '0;
    if (present) begin
      ain = cmd.asel ? '0 : a_q;
      bin = cmd.bsel ? cmd.imm : sh_b;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage.
// Hand-computed expectations, immediate assertions at each check.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [2:0]  writenum;
  logic [15:0] data_in;
  logic        start;
  logic [2:0]  readnum_a;
  logic [2:0]  readnum_b;
  logic [1:0]  shift;
  logic        asel;
  logic        bsel;
  logic [15:0] imm;
  logic [1:0]  alu_op_in;
  logic        accept;
  logic        busy;
  logic        valid;
  logic [15:0] ain;
  logic [15:0] bin;
  logic [1:0]  alu_op;

  int passed = 0;
  int total  = 0;

  operand_fetch_stage dut (
    .clk       (clk),
    .reset     (reset),
    .write     (write),
    .writenum  (writenum),
    .data_in   (data_in),
    .start     (start),
    .readnum_a (readnum_a),
    .readnum_b (readnum_b),
    .shift     (shift),
    .asel      (asel),
    .bsel      (bsel),
    .imm       (imm),
    .alu_op_in (alu_op_in),
    .accept    (accept),
    .busy      (busy),
    .valid     (valid),
    .ain       (ain),
    .bin       (bin),
    .alu_op    (alu_op)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
  endtask

  task automatic wr(input logic [2:0] idx,
                    input logic [15:0] val);
    write    = 1'b1;
    writenum = idx;
    data_in  = val;
    tick();
    write    = 1'b0;
  endtask

  task automatic setup(input logic [2:0] a,
                       input logic [2:0] b,
                       input logic [1:0] sh,
                       input logic as,
                       input logic bs,
                       input logic [15:0] im,
                       input logic [1:0] op);
    readnum_a = a;
    readnum_b = b;
    shift     = sh;
    asel      = as;
    bsel      = bs;
    imm       = im;
    alu_op_in = op;
  endtask

  // Full fetch with accept held high; the start edge is edge 1.
  task automatic fetch(input string tag,
                       input logic [2:0] a,
                       input logic [2:0] b,
                       input logic [1:0] sh,
                       input logic as,
                       input logic bs,
                       input logic [15:0] im,
                       input logic [1:0] op,
                       input logic [15:0] ea,
                       input logic [15:0] eb);
    setup(a, b, sh, as, bs, im, op);
    accept = 1'b1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check({tag, ".busy1"}, busy, 1);
    check({tag, ".valid1"}, valid, 0);
    tick();
    check({tag, ".valid2"}, valid, 0);
    tick();
    check({tag, ".valid3"}, valid, 1);
    check({tag, ".ain"}, ain, ea);
    check({tag, ".bin"}, bin, eb);
    check({tag, ".op"}, alu_op, op);
    tick();
    check({tag, ".busy4"}, busy, 0);
    check({tag, ".valid4"}, valid, 0);
    check({tag, ".ain_idle"}, ain, 0);
    check({tag, ".bin_idle"}, bin, 0);
  endtask

  initial begin
    reset    = 1'b1;
    write    = 1'b1;
    writenum = 3'd3;
    data_in  = 16'hABCD;
    start    = 1'b0;
    accept   = 1'b0;
    setup(3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00);
    tick();
    tick();
    reset = 1'b0;
    write = 1'b0;
    check("rst.busy", busy, 0);
    check("rst.valid", valid, 0);
    check("rst.ain", ain, 0);
    check("rst.bin", bin, 0);
    check("rst.op", alu_op, 0);
    fetch("rst_r3", 3'd3, 3'd3, 2'b00, 1'b0, 1'b0,
          16'h0, 2'b00, 16'h0000, 16'h0000);

    wr(3'd1, 16'd31);
    wr(3'd2, 16'd11);
    fetch("add", 3'd1, 3'd2, 2'b00, 1'b0, 1'b0,
          16'h0, 2'b00, 16'h001F, 16'h000B);

    wr(3'd2, 16'h8005);
    fetch("lsl", 3'd1, 3'd2, 2'b01, 1'b0, 1'b0,
          16'h0, 2'b01, 16'h001F, 16'h000A);
    fetch("lsr", 3'd1, 3'd2, 2'b10, 1'b0, 1'b0,
          16'h0, 2'b10, 16'h001F, 16'h4002);
    fetch("asr", 3'd1, 3'd2, 2'b11, 1'b0, 1'b0,
          16'h0, 2'b11, 16'h001F, 16'hC002);
    fetch("none", 3'd1, 3'd2, 2'b00, 1'b0, 1'b0,
          16'h0, 2'b00, 16'h001F, 16'h8005);
    fetch("sel", 3'd1, 3'd2, 2'b01, 1'b1, 1'b1,
          16'h0007, 2'b10, 16'h0000, 16'h0007);

    // Forward on the LOAD_A edge, then hold with accept low.
    setup(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0, 2'b01);
    accept = 1'b0;
    start  = 1'b1;
    tick();
    start    = 1'b0;
    write    = 1'b1;
    writenum = 3'd1;
    data_in  = 16'h1234;
    tick();
    write = 1'b0;
    tick();
    check("fwd.valid", valid, 1);
    check("fwd.ain", ain, 16'h1234);
    check("fwd.bin", bin, 16'h8005);
    wr(3'd1, 16'h5555);
    check("snap.ain", ain, 16'h1234);
    check("snap.valid", valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold%0d.valid", i), valid, 1);
      check($sformatf("hold%0d.ain", i), ain, 16'h1234);
      check($sformatf("hold%0d.bin", i), bin, 16'h8005);
    end
    setup(3'd3, 3'd3, 2'b01, 1'b1, 1'b1, 16'hFFFF, 2'b11);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start.ain", ain, 16'h1234);
    check("busy_start.bin", bin, 16'h8005);
    check("busy_start.op", alu_op, 2'b01);
    accept = 1'b1;
    tick();
    check("acc.busy", busy, 0);
    check("acc.valid", valid, 0);
    tick();
    check("noqueue.busy", busy, 0);
    fetch("r1_new", 3'd1, 3'd2, 2'b00, 1'b0, 1'b0,
          16'h0, 2'b00, 16'h5555, 16'h8005);

    // Reset on the LOAD_B edge.
    setup(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0, 2'b11);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mid.busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid.busy_rst", busy, 0);
    check("mid.valid_rst", valid, 0);
    check("mid.op_rst", alu_op, 0);
    tick();
    check("mid.idle", busy, 0);
    fetch("mid_clr", 3'd1, 3'd2, 2'b00, 1'b0, 1'b0,
          16'h0, 2'b00, 16'h0000, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
